// File: rtl/flash_word_reader_if.sv
// Bundle of CPU-side and flash-controller-side signals for flash_word_reader.
// The master modport is the reader's own view (it masters the flash bus);
// the slave modport is the view of whatever sits around it.
interface flash_word_reader_if;
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic        cpu_inval;
  logic        cpu_busy;
  logic        cpu_valid;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        f_Hselect;
  logic [22:0] f_Haddress;
  logic        f_Hready;
  logic [15:0] f_Hreaddata;
  logic        f_Hresponse;

  modport master (
    input  cpu_req, cpu_addr, cpu_inval, f_Hready, f_Hreaddata, f_Hresponse,
    output cpu_busy, cpu_valid, cpu_err, cpu_rdata, f_Hselect, f_Haddress
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_inval, f_Hready, f_Hreaddata, f_Hresponse,
    input  cpu_busy, cpu_valid, cpu_err, cpu_rdata, f_Hselect, f_Haddress
  );
endinterface

// File: rtl/flash_word_reader.sv
// Reads a 32-bit word as two 16-bit halfword transfers from a flash
// controller, with an optional one-entry cache of the last word fetched.
module flash_word_reader #(
  parameter int TIMEOUT  = 255,
  parameter bit CACHE_EN = 1'b1
) (
  input logic                 Hclock,
  input logic                 Hreset,
  flash_word_reader_if.master bus
);

  // Counter is at least 8 bits, wider only if TIMEOUT needs it.
  localparam int            CW        = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE, FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [21:0]   addr_q;
  logic [15:0]   lo_q;
  logic          hit_q;
  logic [31:0]   rdata_q;
  logic [22:0]   haddr_q;
  logic          cache_valid_q;
  logic [21:0]   cache_tag_q;
  logic [31:0]   cache_data_q;

  logic cache_hit;
  logic in_xfer;
  logic timed_out;
  logic wait_armed;

  assign cache_hit  = CACHE_EN && cache_valid_q && (bus.cpu_addr[23:2] == cache_tag_q);
  assign in_xfer    = state_q inside {LO_REQ, LO_WAIT, HI_REQ, HI_WAIT};
  assign timed_out  = (cnt_q >= TIMEOUT_C);
  // The controller still shows the ready of the capture edge during the
  // first WAIT cycle, so only a later ready means the data is there.
  assign wait_armed = (cnt_q != '0);

  // Next-state logic: response errors first, then progress, then timeout.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_d, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_addr[1:0] != 2'b00) state_d = FAIL;
          else if (cache_hit)             state_d = DONE;
          else                            state_d = LO_REQ;
        end
      end
      LO_REQ: begin
        if (bus.f_Hresponse)   state_d = FAIL;
        else if (bus.f_Hready) state_d = LO_WAIT;
        else if (timed_out)    state_d = FAIL;
      end
      LO_WAIT: begin
        if (bus.f_Hresponse)                  state_d = FAIL;
        else if (bus.f_Hready && wait_armed)  state_d = HI_REQ;
        else if (timed_out)                   state_d = FAIL;
      end
      HI_REQ: begin
        if (bus.f_Hresponse)   state_d = FAIL;
        else if (bus.f_Hready) state_d = HI_WAIT;
        else if (timed_out)    state_d = FAIL;
      end
      HI_WAIT: begin
        if (bus.f_Hresponse)                  state_d = FAIL;
        else if (bus.f_Hready && wait_armed)  state_d = DONE;
        else if (timed_out)                   state_d = FAIL;
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and per-state saturating wait counter.
  always_ff @(posedge Hclock or negedge Hreset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    if (!Hreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)           cnt_q <= '0;
      else if (in_xfer && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end
  end

  // Visible outputs and cache valid bit; invalidate always has the last word.
  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      rdata_q       <= '0;
      haddr_q       <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == LO_REQ)    haddr_q <= {bus.cpu_addr[23:2], 1'b0};
      if (state_q == LO_WAIT && state_d == HI_REQ) haddr_q <= {addr_q, 1'b1};
      if (state_q == IDLE && state_d == DONE)      rdata_q <= cache_data_q;
      if (state_q == HI_WAIT && state_d == DONE)   rdata_q <= {bus.f_Hreaddata, lo_q};
      if (state_q == DONE && !hit_q)               cache_valid_q <= 1'b1;
      if (state_q == FAIL || bus.cpu_inval)        cache_valid_q <= 1'b0;
    end
  end

  // Request context, low halfword and cache contents.
  always_ff @(posedge Hclock) begin
    // NOTE: no reset here: these are only read after a request or a valid bit has qualified them.
    if (state_q == IDLE && bus.cpu_req) begin
      addr_q <= bus.cpu_addr[23:2];
      hit_q  <= cache_hit;
    end
    if (state_q == LO_WAIT && state_d == HI_REQ) lo_q <= bus.f_Hreaddata;
    if (state_q == DONE && !hit_q) begin
      cache_tag_q  <= addr_q;
      cache_data_q <= rdata_q;
    end
  end

  assign bus.cpu_busy   = (state_q != IDLE);
  assign bus.cpu_valid  = (state_q == DONE);
  assign bus.cpu_err    = (state_q == FAIL);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.f_Hselect  = (state_q == LO_REQ) || (state_q == HI_REQ);
  assign bus.f_Haddress = haddr_q;

endmodule

// File: tb/tb_flash_word_reader.sv
// Self-checking bench for flash_word_reader: a vector table, hand-written
// timeout / error / reset sequences, and randomized requests scored against
// a word-level cache and memory model.
module tb_flash_word_reader;

  localparam int TIMEOUT = 16;

  logic Hclock = 1'b0;
  logic Hreset = 1'b1;

  always #5 Hclock = ~Hclock;

  flash_word_reader_if bus();

  flash_word_reader #(.TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (
    .Hclock (Hclock),
    .Hreset (Hreset),
    .bus    (bus)
  );

  typedef struct {
    logic [23:0] addr;
    bit          inval_pre;
    bit          inval_done;
    bit          noise;
    bit          exp_err;
    logic [31:0] exp_data;
    int          exp_sels;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          valid;
    bit          err;
    logic [31:0] data;
    int          sels;
    int          lat;
    int          pulses;
    int          waits;
    bit          timed_out;
  } res_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Flash contents: two fixed halfwords, everything else a simple hash.
  function automatic logic [15:0] flash_data(input logic [22:0] a);
    if (a == 23'h000080) return 16'h1234;
    if (a == 23'h000081) return 16'hABCD;
    return {a[7:0], a[15:8]} ^ {9'd0, a[22:16]} ^ 16'h5AC3;
  endfunction

  function automatic logic [31:0] word_of(input logic [23:0] addr);
    return {flash_data({addr[23:2], 1'b1}), flash_data({addr[23:2], 1'b0})};
  endfunction

  // Flash controller model: ready when idle, busy for lat cycles after capture.
  int          lat          = 6;
  int          busy_cnt     = 0;
  logic        cur_hi       = 1'b0;
  logic [15:0] fdata        = 16'h0000;
  logic        resp_hi_mode = 1'b0;
  logic        model_flush  = 1'b0;

  assign bus.f_Hready    = (busy_cnt == 0);
  assign bus.f_Hreaddata = fdata;
  assign bus.f_Hresponse = resp_hi_mode && cur_hi && (busy_cnt != 0);

  // Controller capture and busy countdown.
  always @(posedge Hclock) begin
    if (model_flush) begin
      busy_cnt <= 0;
    end else if (bus.f_Hselect && busy_cnt == 0) begin
      busy_cnt <= lat;
      fdata    <= flash_data(bus.f_Haddress);
      cur_hi   <= bus.f_Haddress[0];
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Event counters sampled mid-cycle.
  int sel_acc   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int sel_idle  = 0;

  always @(negedge Hclock) begin
    if (bus.f_Hselect && bus.f_Hready) sel_acc   <= sel_acc + 1;
    if (bus.cpu_valid)                 valid_cnt <= valid_cnt + 1;
    if (bus.cpu_err)                   err_cnt   <= err_cnt + 1;
    if (bus.f_Hselect && !bus.cpu_busy) sel_idle <= sel_idle + 1;
  end

  task automatic tick();
    @(negedge Hclock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush_model();
    model_flush = 1'b1;
    tick();
    model_flush = 1'b0;
  endtask

  // One CPU request: optional invalidate before it / in its DONE cycle and
  // optional extra request while busy; collects what the reader did.
  task automatic do_req(input logic [23:0] addr, input bit inval_pre, input bit inval_done,
                        input bit noise, input int budget, output res_t r);
    int s0;
    int p0;
    r.valid = 1'b0; r.err = 1'b0; r.data = '0; r.sels = 0;
    r.lat = 0; r.pulses = 0; r.waits = 0; r.timed_out = 1'b1;
    if (inval_pre) begin
      bus.cpu_inval = 1'b1;
      tick();
      bus.cpu_inval = 1'b0;
    end
    s0 = sel_acc;
    p0 = valid_cnt + err_cnt;
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (i == 1) bus.cpu_req = 1'b0;
      if (noise && i == 3) begin
        bus.cpu_addr = addr ^ 24'h000040;
        bus.cpu_req  = 1'b1;
      end
      if (noise && i == 4) bus.cpu_req = 1'b0;
      if (bus.cpu_valid || bus.cpu_err) begin
        r.valid     = bus.cpu_valid;
        r.err       = bus.cpu_err;
        r.data      = bus.cpu_rdata;
        r.lat       = i;
        r.timed_out = 1'b0;
        break;
      end
      if (bus.cpu_busy && !bus.f_Hselect) r.waits++;
    end
    bus.cpu_req = 1'b0;
    if (!r.timed_out && r.valid && inval_done) bus.cpu_inval = 1'b1;
    tick();
    bus.cpu_inval = 1'b0;
    tick();
    tick();
    r.sels   = sel_acc - s0;
    r.pulses = valid_cnt + err_cnt - p0;
  endtask

  task automatic check_res(input string tag, input res_t r, input bit exp_err,
                           input logic [31:0] exp_data, input int exp_sels, input int exp_lat);
    check({tag, "_no_timeout"}, 32'(r.timed_out), 32'd0);
    check({tag, "_err"},        32'(r.err),       32'(exp_err));
    check({tag, "_valid"},      32'(r.valid),     32'(!exp_err));
    check({tag, "_rdata"},      r.data,           exp_data);
    check({tag, "_flash_reqs"}, r.sels,           exp_sels);
    check({tag, "_pulses"},     r.pulses,         32'd1);
    if (exp_lat != 0) check({tag, "_latency"}, r.lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[15];
    res_t        r;
    int          s0;
    int          p0;
    bit          found;
    int          busy_seen;
    logic [31:0] w100;
    logic        ref_valid;
    logic [21:0] ref_tag;
    logic [31:0] ref_data;
    logic [31:0] ref_rdata;
    logic [23:0] a;
    logic [23:0] prev_a;
    bit          ip, id, nz, exp_err, miss;
    logic [31:0] exp_data;
    int          exp_sels, exp_lat;

    w100 = 32'hABCD1234;
    vecs[0]  = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 2, 0};
    vecs[1]  = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 0, 1};
    vecs[2]  = '{24'h000100, 1'b1, 1'b0, 1'b0, 1'b0, w100,                 2, 0};
    vecs[3]  = '{24'h000102, 1'b0, 1'b0, 1'b0, 1'b1, w100,                 0, 1};
    vecs[4]  = '{24'h000100, 1'b0, 1'b0, 1'b1, 1'b0, w100,                 2, 0};
    vecs[5]  = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 0, 1};
    vecs[6]  = '{24'h000200, 1'b0, 1'b1, 1'b0, 1'b0, word_of(24'h000200), 2, 0};
    vecs[7]  = '{24'h000200, 1'b0, 1'b0, 1'b0, 1'b0, word_of(24'h000200), 2, 0};
    vecs[8]  = '{24'h000200, 1'b0, 1'b0, 1'b0, 1'b0, word_of(24'h000200), 0, 1};
    vecs[9]  = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 2, 0};
    vecs[10] = '{24'hFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, word_of(24'hFFFFFC), 2, 0};
    vecs[11] = '{24'hFFFFFC, 1'b0, 1'b0, 1'b0, 1'b0, word_of(24'hFFFFFC), 0, 1};
    vecs[12] = '{24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, word_of(24'hFFFFFC), 0, 1};
    vecs[13] = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 2, 0};
    vecs[14] = '{24'h000100, 1'b0, 1'b0, 1'b0, 1'b0, w100,                 0, 1};

    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_inval = 1'b0;

    // Reset state.
    #1 Hreset = 1'b0;
    tick();
    check("reset_busy",     32'(bus.cpu_busy),  32'd0);
    check("reset_valid",    32'(bus.cpu_valid), 32'd0);
    check("reset_err",      32'(bus.cpu_err),   32'd0);
    check("reset_rdata",    bus.cpu_rdata,      32'd0);
    check("reset_hselect",  32'(bus.f_Hselect), 32'd0);
    check("reset_haddress", 32'(bus.f_Haddress), 32'd0);
    Hreset = 1'b1;
    tick();

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].addr, vecs[i].inval_pre, vecs[i].inval_done, vecs[i].noise, 100, r);
      check_res($sformatf("vec%0d", i), r, vecs[i].exp_err, vecs[i].exp_data,
                vecs[i].exp_sels, vecs[i].exp_lat);
    end

    // Timeout: controller never finishes the low halfword.
    lat = 1000;
    do_req(24'h000300, 1'b0, 1'b0, 1'b0, 100, r);
    check_res("timeout", r, 1'b1, w100, 1, 0);
    check("timeout_wait_cycles_in_range", 32'(r.waits >= TIMEOUT && r.waits <= TIMEOUT + 1), 32'd1);
    lat = 6;
    flush_model();
    check("timeout_back_idle", 32'(bus.cpu_busy), 32'd0);
    do_req(24'h000100, 1'b0, 1'b0, 1'b0, 100, r);
    check_res("after_timeout_miss", r, 1'b0, w100, 2, 0);

    // Error response during the high-halfword wait.
    resp_hi_mode = 1'b1;
    do_req(24'h000300, 1'b0, 1'b0, 1'b0, 100, r);
    check_res("hi_resp_err", r, 1'b1, w100, 2, 0);
    resp_hi_mode = 1'b0;
    flush_model();
    do_req(24'h000300, 1'b0, 1'b0, 1'b0, 100, r);
    check_res("after_resp_miss", r, 1'b0, word_of(24'h000300), 2, 0);

    // Reset while waiting on the high halfword.
    s0 = sel_acc;
    bus.cpu_addr = 24'h000400;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sel_acc - s0 >= 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_reached_hi_phase", 32'(found), 32'd1);
    tick();
    check("rst_pre_busy", 32'(bus.cpu_busy), 32'd1);
    Hreset = 1'b0;
    #1;
    check("rst_mid_busy",     32'(bus.cpu_busy),   32'd0);
    check("rst_mid_valid",    32'(bus.cpu_valid),  32'd0);
    check("rst_mid_err",      32'(bus.cpu_err),    32'd0);
    check("rst_mid_rdata",    bus.cpu_rdata,       32'd0);
    check("rst_mid_hselect",  32'(bus.f_Hselect),  32'd0);
    check("rst_mid_haddress", 32'(bus.f_Haddress), 32'd0);
    tick();
    Hreset = 1'b1;
    p0 = valid_cnt + err_cnt;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.cpu_busy) busy_seen++;
    end
    check("rst_release_pulses", valid_cnt + err_cnt - p0, 32'd0);
    check("rst_release_busy",   busy_seen,                32'd0);
    flush_model();
    do_req(24'h000400, 1'b0, 1'b0, 1'b0, 100, r);
    check_res("after_reset_miss", r, 1'b0, word_of(24'h000400), 2, 0);

    // Randomized requests against a word-level reference.
    ref_valid = 1'b1;
    ref_tag   = 22'h000100;
    ref_data  = word_of(24'h000400);
    ref_rdata = word_of(24'h000400);
    prev_a    = 24'h000400;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: a = 24'h000100;
        1: a = 24'h000104;
        2: a = 24'h000200;
        3: a = 24'hFFFFFC;
        4: a = prev_a;
        5: begin a = 24'($urandom); a[1:0] = 2'b00; end
        default: begin a = 24'($urandom); a[1:0] = 2'($urandom_range(1, 3)); end
      endcase
      ip  = ($urandom_range(0, 4) == 0);
      id  = ($urandom_range(0, 4) == 0);
      lat = $urandom_range(1, 8);
      if (ip) ref_valid = 1'b0;
      miss = 1'b0;
      if (a[1:0] != 2'b00) begin
        exp_err = 1'b1; exp_data = ref_rdata; exp_sels = 0; exp_lat = 1;
        ref_valid = 1'b0;
      end else if (ref_valid && ref_tag == a[23:2]) begin
        exp_err = 1'b0; exp_data = ref_data; exp_sels = 0; exp_lat = 1;
        ref_rdata = ref_data;
        if (id) ref_valid = 1'b0;
      end else begin
        miss = 1'b1;
        exp_err = 1'b0; exp_data = word_of(a); exp_sels = 2; exp_lat = 0;
        ref_rdata = exp_data;
        ref_data  = exp_data;
        ref_tag   = a[23:2];
        ref_valid = !id;
      end
      nz = miss && ($urandom_range(0, 2) == 0);
      do_req(a, ip, id, nz, 100, r);
      check_res($sformatf("rand%0d_a%06h", n, a), r, exp_err, exp_data, exp_sels, exp_lat);
      prev_a = a;
    end

    check("select_while_idle", sel_idle, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
